bullet_arena: RTL and testbench
===============================

Name: bullet_arena

Overview:
- Parametrised successor to the single-bullet path: one block owns N bullet slots and handles spawn, movement, sequential collision scan against the player box, colour-dependent damage/heal, and the player HP counter.
- Sits between the battle state machine (run/spawn control, wave completion) and the VGA renderer (indexed slot readout).

Parameters:
N_BULLETS, 8, number of bullet slots (2..16)
COORD_W, 8, coordinate and size width
HP_W, 8, HP counter width
HP_MAX, 100, HP after reset or hp_reload
DMG, 5, HP lost per damaging hit
HEAL, 3, HP gained per green hit
X_MIN/X_MAX/Y_MIN/Y_MAX, 0/255/0/255, arena bounds (inclusive)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle move strobe (one step per tick)
run  in  1  wave enable from battle machine
hp_reload  in  1  one-cycle pulse: hp<=HP_MAX, clear is_death
spawn_valid  in  1  spawn request
spawn_ready  out  1  spawn accepted when valid&ready
spawn_x, spawn_y  in  COORD_W  initial top-left position
spawn_dx, spawn_dy  in  4  signed velocity per tick
spawn_size  in  COORD_W  square bullet edge length
spawn_color  in  3  effect code
player_x, player_y, player_size  in  COORD_W  player box
player_moving  in  1  player moved this frame
rd_index  in  $clog2(N_BULLETS)  render slot select
rd_pos  out  2*COORD_W  {x,y} of selected slot
rd_size  out  COORD_W  size of selected slot
rd_color  out  3  colour of selected slot
rd_active  out  1  selected slot is live
hp  out  HP_W  player HP
is_death  out  1  sticky, set when hp reaches 0
hit_pulse  out  1  one-cycle pulse on an effective hit
hit_index  out  $clog2(N_BULLETS)  slot of the last hit
active_count  out  $clog2(N_BULLETS)+1  number of live slots
wave_done  out  1  one-cycle pulse when a drained wave completes
tick_overrun  out  1  sticky; a tick was dropped

Behaviour:
- Reset (async): all slots inactive, hp=HP_MAX, all flags/pulses 0, rd_* 0, state IDLE.
- States: IDLE, RUN, MOVE, SCAN, DRAIN, DONE.
- IDLE -> RUN on run=1. Entering RUN clears all slots.
- RUN: spawn_ready=1 iff any slot is free and is_death=0. On accept, the lowest free index takes the spawn fields and becomes active the next cycle.
- RUN: a tick, or a pending tick, moves to MOVE. run=0 moves to DRAIN.
- MOVE (1 cycle), all slots in parallel:
  - x += sign-extended dx, y += dy, computed at COORD_W+1 bits.
  - A slot whose result falls outside [X_MIN,X_MAX]/[Y_MIN,Y_MAX], or under/overflows, is deactivated.
  - spawn_ready=0.
- SCAN: exactly N_BULLETS cycles, slot i on scan cycle i. Spawns are allowed during SCAN.
  - Collision test: active && bx<px+ps && px<bx+bs && by<py+ps && py<by+bs, computed at COORD_W+1 bits (no wrap).
  - On hit the slot is always consumed (deactivated).
  - Effect by colour:
    - 0 white, 4-7: damage
    - 1 blue: damage only if player_moving
    - 2 orange: damage only if !player_moving
    - 3 green: heal
  - hit_pulse/hit_index assert only when the effect applies.
  - hp saturates at 0 and at HP_MAX.
  - hp reaching 0 sets is_death. While is_death=1, hits are consumed with no effect.
- After SCAN: return to RUN, or to DRAIN if run=0.
- Tick outside RUN: latched into a one-deep pending flag. A tick arriving while pending is set is dropped and sets tick_overrun (cleared by reset only).
- DRAIN: no spawns; ticks still move and scan via MOVE/SCAN. When active_count==0, go to DONE.
- DONE (1 cycle): wave_done=1, then IDLE.
- Simultaneous events:
  - hp_reload in the same cycle as a hit: the reload wins.
  - Spawn into a slot deactivated in the same cycle is not permitted; only slots free at the start of the cycle are eligible.
- rd_*: registered, 1-cycle latency from rd_index. Indices ≥ N_BULLETS return rd_active=0.
- Tick-to-scan-complete latency: 1 + N_BULLETS cycles.

Decomposition:
- Package battle_pkg: colour codes (WHITE=0, BLUE=1, ORANGE=2, GREEN=3), state enum, default DMG/HEAL/HP_MAX.
- Sub-module collision_check: combinational AABB overlap, parametrised on COORD_W. Reused by other hitbox logic.

Test Plan:
- Reset, then run=1, spawn 8 bullets back-to-back -> spawn_ready=0 after the 8th; active_count=8; slots 0..7 filled in order.
- White bullet at (40,40) size 8, player at (44,44) size 16, one tick with dx=dy=0 -> hit_pulse on scan cycle 0, hit_index=0, hp 100->95, slot freed.
- Blue bullet overlapping with player_moving=0 -> slot freed, no hit_pulse, hp unchanged. Repeat with player_moving=1 -> hp -5.
- hp=98, green hit -> hp=100 (saturated). hp=3, white hit -> hp=0, is_death=1. Further white hits -> hp stays 0. hp_reload -> hp=100, is_death=0.
- Bullet at x=250, dx=+7, tick -> deactivated at MOVE. Then run=0 with 2 live bullets leaving the arena over 3 ticks -> wave_done pulses once after the last exits, then IDLE.
- Two ticks during SCAN -> first executed after SCAN, second dropped, tick_overrun=1. Assert reset mid-SCAN -> all slots cleared and hp=100 immediately.

Source files
------------

// File: rtl/battle_pkg.sv
// rtl/battle_pkg.sv - shared state, colour and effect definitions for the battle datapath
package battle_pkg;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_MOVE, S_SCAN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {E_NONE, E_DMG, E_HEAL} effect_t;

  localparam logic [2:0] C_WHITE  = 3'd0;
  localparam logic [2:0] C_BLUE   = 3'd1;
  localparam logic [2:0] C_ORANGE = 3'd2;
  localparam logic [2:0] C_GREEN  = 3'd3;

  localparam int DEF_HP_MAX = 100;
  localparam int DEF_DMG    = 5;
  localparam int DEF_HEAL   = 3;

  // Blue punishes moving through it, orange punishes standing still.
  function automatic effect_t color_effect(input logic [2:0] color, input logic moving);
    case (color)
      C_WHITE:  color_effect = E_DMG;
      C_BLUE:   color_effect = moving ? E_DMG : E_NONE;
      C_ORANGE: color_effect = moving ? E_NONE : E_DMG;
      C_GREEN:  color_effect = E_HEAL;
      default:  color_effect = E_DMG;
    endcase
  endfunction

endpackage

// File: rtl/collision_check.sv
// rtl/collision_check.sv - combinational AABB overlap of two square boxes
// Box ends are formed one bit wider so edges near the coordinate limit never wrap.
module collision_check #(
  parameter int COORD_W = 8
) (
  input  logic [COORD_W-1:0] i_ax,
  input  logic [COORD_W-1:0] i_ay,
  input  logic [COORD_W-1:0] i_asize,
  input  logic [COORD_W-1:0] i_bx,
  input  logic [COORD_W-1:0] i_by,
  input  logic [COORD_W-1:0] i_bsize,
  output logic               o_overlap
);

  logic [COORD_W:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;

  assign w_ax_end = {1'b0, i_ax} + {1'b0, i_asize};
  assign w_ay_end = {1'b0, i_ay} + {1'b0, i_asize};
  assign w_bx_end = {1'b0, i_bx} + {1'b0, i_bsize};
  assign w_by_end = {1'b0, i_by} + {1'b0, i_bsize};

  assign o_overlap = ({1'b0, i_ax} < w_bx_end) && ({1'b0, i_bx} < w_ax_end) &&
                     ({1'b0, i_ay} < w_by_end) && ({1'b0, i_by} < w_ay_end);

endmodule

// File: rtl/bullet_arena.sv
// rtl/bullet_arena.sv - N-slot bullet pool: spawn, move, sequential player hit scan, HP
// Slots move in parallel on a tick, then one slot per cycle is tested against the player box.
module bullet_arena
  import battle_pkg::*;
#(
  parameter int N_BULLETS = 8,
  parameter int COORD_W   = 8,
  parameter int HP_W      = 8,
  parameter int HP_MAX    = DEF_HP_MAX,
  parameter int DMG       = DEF_DMG,
  parameter int HEAL      = DEF_HEAL,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 255,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 255,
  localparam int IW       = $clog2(N_BULLETS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_run,
  input  logic                 i_hp_reload,
  input  logic                 i_spawn_valid,
  output logic                 o_spawn_ready,
  input  logic [COORD_W-1:0]   i_spawn_x,
  input  logic [COORD_W-1:0]   i_spawn_y,
  input  logic [3:0]           i_spawn_dx,
  input  logic [3:0]           i_spawn_dy,
  input  logic [COORD_W-1:0]   i_spawn_size,
  input  logic [2:0]           i_spawn_color,
  input  logic [COORD_W-1:0]   i_player_x,
  input  logic [COORD_W-1:0]   i_player_y,
  input  logic [COORD_W-1:0]   i_player_size,
  input  logic                 i_player_moving,
  input  logic [IW-1:0]        i_rd_index,
  output logic [2*COORD_W-1:0] o_rd_pos,
  output logic [COORD_W-1:0]   o_rd_size,
  output logic [2:0]           o_rd_color,
  output logic                 o_rd_active,
  output logic [HP_W-1:0]      o_hp,
  output logic                 o_is_death,
  output logic                 o_hit_pulse,
  output logic [IW-1:0]        o_hit_index,
  output logic [IW:0]          o_active_count,
  output logic                 o_wave_done,
  output logic                 o_tick_overrun
);

  logic [COORD_W-1:0]   r_x [N_BULLETS];
  logic [COORD_W-1:0]   r_y [N_BULLETS];
  logic [COORD_W-1:0]   r_size [N_BULLETS];
  logic [3:0]           r_dx [N_BULLETS];
  logic [3:0]           r_dy [N_BULLETS];
  logic [2:0]           r_color [N_BULLETS];
  logic [N_BULLETS-1:0] r_active;
  state_t               r_state;
  logic [IW-1:0]        r_scan_idx;
  logic                 r_pending, r_overrun;
  logic [HP_W-1:0]      r_hp;
  logic                 r_death, r_hit_pulse, r_wave_done;
  logic [IW-1:0]        r_hit_index;
  logic [2*COORD_W-1:0] r_rd_pos;
  logic [COORD_W-1:0]   r_rd_size;
  logic [2:0]           r_rd_color;
  logic                 r_rd_active;

  int                   w_nx [N_BULLETS];
  int                   w_ny [N_BULLETS];
  logic [N_BULLETS-1:0] w_keep;
  logic                 w_any_free, w_spawn_ready, w_spawn_fire, w_tick_go, w_take;
  logic [IW-1:0]        w_free_idx;
  logic [IW:0]          w_count;
  logic                 w_overlap, w_hit;
  effect_t              w_eff;

  // Candidate slot uses r_active only, so a slot freed this cycle is never reused in the same cycle.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    w_count    = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_any_free = 1'b1;
        w_free_idx = IW'(i);
      end
      w_count = w_count + {{IW{1'b0}}, r_active[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < N_BULLETS; i++) begin
      w_nx[i]   = int'(r_x[i]) + int'($signed(r_dx[i]));
      w_ny[i]   = int'(r_y[i]) + int'($signed(r_dy[i]));
      w_keep[i] = (w_nx[i] >= X_MIN) && (w_nx[i] <= X_MAX) && (w_nx[i] < (1 << COORD_W)) &&
                  (w_ny[i] >= Y_MIN) && (w_ny[i] <= Y_MAX) && (w_ny[i] < (1 << COORD_W));
    end
  end

  collision_check #(.COORD_W(COORD_W)) u_collision (
    .i_ax     (r_x[r_scan_idx]),
    .i_ay     (r_y[r_scan_idx]),
    .i_asize  (r_size[r_scan_idx]),
    .i_bx     (i_player_x),
    .i_by     (i_player_y),
    .i_bsize  (i_player_size),
    .o_overlap(w_overlap)
  );

  assign w_hit         = (r_state == S_SCAN) && r_active[r_scan_idx] && w_overlap;
  assign w_eff         = color_effect(r_color[r_scan_idx], i_player_moving);
  assign w_spawn_ready = ((r_state == S_RUN) || (r_state == S_SCAN)) && w_any_free && !r_death;
  assign w_spawn_fire  = w_spawn_ready && i_spawn_valid;
  assign w_tick_go     = i_tick || r_pending;
  assign w_take        = w_tick_go && ((r_state == S_RUN) || ((r_state == S_DRAIN) && (w_count != '0)));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_active    <= '0;
      r_scan_idx  <= '0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_hp        <= HP_W'(HP_MAX);
      r_death     <= 1'b0;
      r_hit_pulse <= 1'b0;
      r_hit_index <= '0;
      r_wave_done <= 1'b0;
      r_rd_pos    <= '0;
      r_rd_size   <= '0;
      r_rd_color  <= '0;
      r_rd_active <= 1'b0;
      for (int i = 0; i < N_BULLETS; i++) begin
        r_x[i]     <= '0;
        r_y[i]     <= '0;
        r_size[i]  <= '0;
        r_dx[i]    <= '0;
        r_dy[i]    <= '0;
        r_color[i] <= '0;
      end
    end else begin
      r_hit_pulse <= 1'b0;
      r_wave_done <= 1'b0;
      // A tick that cannot be acted on now waits in a one-deep slot; a second one is lost.
      if (w_take) begin
        r_pending <= r_pending && i_tick;
      end else if (i_tick) begin
        if (r_pending) r_overrun <= 1'b1;
        r_pending <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (i_run) begin
          r_state  <= S_RUN;
          r_active <= '0;
        end
        S_RUN: begin
          if (w_tick_go) r_state <= S_MOVE;
          else if (!i_run) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_count == '0) begin
            r_state     <= S_DONE;
            r_wave_done <= 1'b1;
          end else if (w_tick_go) begin
            r_state <= S_MOVE;
          end
        end
        S_MOVE: begin
          for (int i = 0; i < N_BULLETS; i++) begin
            r_x[i] <= COORD_W'(w_nx[i]);
            r_y[i] <= COORD_W'(w_ny[i]);
          end
          r_active   <= r_active & w_keep;
          r_scan_idx <= '0;
          r_state    <= S_SCAN;
        end
        S_SCAN: begin
          if (w_hit) begin
            r_active[r_scan_idx] <= 1'b0;
            if (!r_death && (w_eff != E_NONE)) begin
              r_hit_pulse <= 1'b1;
              r_hit_index <= r_scan_idx;
              if (w_eff == E_HEAL) begin
                r_hp <= (r_hp >= HP_W'(HP_MAX - HEAL)) ? HP_W'(HP_MAX) : r_hp + HP_W'(HEAL);
              end else if (r_hp > HP_W'(DMG)) begin
                r_hp <= r_hp - HP_W'(DMG);
              end else begin
                r_hp    <= '0;
                r_death <= 1'b1;
              end
            end
          end
          if (r_scan_idx == IW'(N_BULLETS - 1)) r_state <= i_run ? S_RUN : S_DRAIN;
          else r_scan_idx <= r_scan_idx + IW'(1);
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_spawn_fire) begin
        r_x[w_free_idx]      <= i_spawn_x;
        r_y[w_free_idx]      <= i_spawn_y;
        r_dx[w_free_idx]     <= i_spawn_dx;
        r_dy[w_free_idx]     <= i_spawn_dy;
        r_size[w_free_idx]   <= i_spawn_size;
        r_color[w_free_idx]  <= i_spawn_color;
        r_active[w_free_idx] <= 1'b1;
      end
      if (i_hp_reload) begin
        r_hp    <= HP_W'(HP_MAX);
        r_death <= 1'b0;
      end
      if (int'(i_rd_index) < N_BULLETS) begin
        r_rd_pos    <= {r_x[i_rd_index], r_y[i_rd_index]};
        r_rd_size   <= r_size[i_rd_index];
        r_rd_color  <= r_color[i_rd_index];
        r_rd_active <= r_active[i_rd_index];
      end else begin
        r_rd_pos    <= '0;
        r_rd_size   <= '0;
        r_rd_color  <= '0;
        r_rd_active <= 1'b0;
      end
    end
  end

  assign o_spawn_ready  = w_spawn_ready;
  assign o_rd_pos       = r_rd_pos;
  assign o_rd_size      = r_rd_size;
  assign o_rd_color     = r_rd_color;
  assign o_rd_active    = r_rd_active;
  assign o_hp           = r_hp;
  assign o_is_death     = r_death;
  assign o_hit_pulse    = r_hit_pulse;
  assign o_hit_index    = r_hit_index;
  assign o_active_count = w_count;
  assign o_wave_done    = r_wave_done;
  assign o_tick_overrun = r_overrun;

endmodule

// File: tb/tb_bullet_arena.sv
// tb/tb_bullet_arena.sv - scoreboard bench for bullet_arena
module tb_bullet_arena;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick, run, hp_reload, spawn_valid, spawn_ready;
  logic [7:0]  spawn_x, spawn_y, spawn_size;
  logic [3:0]  spawn_dx, spawn_dy;
  logic [2:0]  spawn_color;
  logic [7:0]  player_x, player_y, player_size;
  logic        player_moving;
  logic [2:0]  rd_index;
  logic [15:0] rd_pos;
  logic [7:0]  rd_size;
  logic [2:0]  rd_color;
  logic        rd_active;
  logic [7:0]  hp;
  logic        is_death, hit_pulse, wave_done, tick_overrun;
  logic [2:0]  hit_index;
  logic [3:0]  active_count;

  int total = 0;
  int bad = 0;
  int wd_seen = 0;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] hp;
    logic       death;
  } hit_t;
  hit_t exp_q[$];
  hit_t e_mon;

  bullet_arena dut (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_run(run), .i_hp_reload(hp_reload),
    .i_spawn_valid(spawn_valid), .o_spawn_ready(spawn_ready),
    .i_spawn_x(spawn_x), .i_spawn_y(spawn_y), .i_spawn_dx(spawn_dx), .i_spawn_dy(spawn_dy),
    .i_spawn_size(spawn_size), .i_spawn_color(spawn_color),
    .i_player_x(player_x), .i_player_y(player_y), .i_player_size(player_size),
    .i_player_moving(player_moving), .i_rd_index(rd_index),
    .o_rd_pos(rd_pos), .o_rd_size(rd_size), .o_rd_color(rd_color), .o_rd_active(rd_active),
    .o_hp(hp), .o_is_death(is_death), .o_hit_pulse(hit_pulse), .o_hit_index(hit_index),
    .o_active_count(active_count), .o_wave_done(wave_done), .o_tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && wave_done) wd_seen++;
    if (!rst && hit_pulse) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL hit_unexpected got idx=%0d hp=%0d want no hit", hit_index, hp);
      end else begin
        e_mon = exp_q.pop_front();
        if (hit_index !== e_mon.idx || hp !== e_mon.hp || is_death !== e_mon.death) begin
          bad++;
          $display("FAIL hit got idx=%0d hp=%0d death=%0b want idx=%0d hp=%0d death=%0b",
                   hit_index, hp, is_death, e_mon.idx, e_mon.hp, e_mon.death);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic spawn(input int x, input int y, input int dx, input int dy, input int sz, input int col);
    int n = 0;
    while (!spawn_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!spawn_ready) begin
      total++;
      bad++;
      $display("FAIL spawn_timeout got ready=%0b want=1", spawn_ready);
    end
    spawn_x = 8'(x); spawn_y = 8'(y); spawn_dx = 4'(dx); spawn_dy = 4'(dy);
    spawn_size = 8'(sz); spawn_color = 3'(col); spawn_valid = 1'b1;
    @(negedge clk);
    spawn_valid = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc(N + 4);
  endtask

  task automatic expect_hit(input int idx, input int h, input int d);
    hit_t t;
    t.idx = 3'(idx); t.hp = 8'(h); t.death = 1'(d);
    exp_q.push_back(t);
  endtask

  task automatic reload();
    hp_reload = 1'b1;
    @(negedge clk);
    hp_reload = 1'b0;
  endtask

  task automatic restart();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    run = 1'b1;
    cyc(2);
  endtask

  initial begin
    tick = 0; run = 0; hp_reload = 0; spawn_valid = 0;
    spawn_x = 0; spawn_y = 0; spawn_dx = 0; spawn_dy = 0; spawn_size = 0; spawn_color = 0;
    player_x = 0; player_y = 200; player_size = 4; player_moving = 0; rd_index = 0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_hp", hp, 100);
    chk("rst_death", is_death, 0);
    chk("rst_ready_idle", spawn_ready, 0);
    chk("rst_count", active_count, 0);
    chk("rst_overrun", tick_overrun, 0);
    chk("rst_rd_active", rd_active, 0);
    chk("rst_rd_pos", rd_pos, 0);
    chk("rst_wave_done", wave_done, 0);

    // fill all slots back-to-back
    run = 1'b1;
    cyc(1);
    for (int k = 0; k < N; k++) begin
      chk("fill_ready", spawn_ready, 1);
      spawn_x = 8'(10 + 20 * k); spawn_y = 8'd10; spawn_dx = 0; spawn_dy = 0;
      spawn_size = 8'd4; spawn_color = 3'(k); spawn_valid = 1'b1;
      @(negedge clk);
    end
    spawn_valid = 1'b0;
    chk("full_ready", spawn_ready, 0);
    chk("full_count", active_count, 8);
    for (int k = 0; k < N; k++) begin
      rd_index = 3'(k);
      cyc(1);
      chk("fill_rd_pos", rd_pos, {8'(10 + 20 * k), 8'd10});
      chk("fill_rd_color", rd_color, k);
      chk("fill_rd_active", rd_active, 1);
    end

    // colour effects against a stationary overlapping player
    restart();
    player_x = 44; player_y = 44; player_size = 16;
    spawn(40, 40, 0, 0, 8, 0); expect_hit(0, 95, 0); do_tick();
    chk("white_hp", hp, 95);
    chk("white_freed", active_count, 0);
    spawn(40, 40, 0, 0, 8, 1); do_tick();
    chk("blue_still_hp", hp, 95);
    chk("blue_still_freed", active_count, 0);
    player_moving = 1;
    spawn(40, 40, 0, 0, 8, 1); expect_hit(0, 90, 0); do_tick();
    player_moving = 0;
    chk("blue_moving_hp", hp, 90);
    spawn(40, 40, 0, 0, 8, 2); expect_hit(0, 85, 0); do_tick();
    chk("orange_hp", hp, 85);

    reload();
    chk("reload_hp", hp, 100);
    spawn(40, 40, 0, 0, 8, 0); spawn(40, 40, 0, 0, 8, 3); spawn(40, 40, 0, 0, 8, 3);
    expect_hit(0, 95, 0); expect_hit(1, 98, 0); expect_hit(2, 100, 0);
    do_tick();
    chk("heal_sat_hp", hp, 100);
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < N; k++) begin
        spawn(40, 40, 0, 0, 8, 0);
        expect_hit(k, 95 - 5 * k - 40 * w, 0);
      end
      do_tick();
    end
    chk("wave_hp", hp, 20);
    for (int k = 0; k < N; k++) spawn(40, 40, 0, 0, 8, (k == 3) ? 3 : 0);
    expect_hit(0, 15, 0); expect_hit(1, 10, 0); expect_hit(2, 5, 0);
    expect_hit(3, 8, 0);  expect_hit(4, 3, 0);  expect_hit(5, 0, 1);
    do_tick();
    chk("death_hp", hp, 0);
    chk("death_flag", is_death, 1);
    chk("death_consumed", active_count, 0);
    chk("death_ready", spawn_ready, 0);
    reload();
    chk("revive_hp", hp, 100);
    chk("revive_flag", is_death, 0);
    chk("revive_ready", spawn_ready, 1);

    // movement and arena bounds
    restart();
    player_x = 0; player_y = 200; player_size = 4;
    spawn(250, 100, 7, 0, 4, 0); spawn(2, 100, -3, 0, 4, 0); spawn(100, 100, 7, -2, 4, 0);
    do_tick();
    chk("bounds_count", active_count, 1);
    rd_index = 3'd2;
    cyc(1);
    chk("move_rd_pos", rd_pos, {8'd107, 8'd98});
    chk("move_rd_active", rd_active, 1);
    rd_index = 3'd0;
    cyc(1);
    chk("overflow_rd_active", rd_active, 0);

    // drain: two bullets leave on the third tick
    restart();
    wd_seen = 0;
    spawn(240, 50, 7, 0, 4, 0); spawn(50, 10, 0, -4, 4, 0);
    run = 1'b0;
    cyc(2);
    do_tick();
    chk("drain_t1_count", active_count, 2);
    do_tick();
    chk("drain_t2_count", active_count, 2);
    chk("drain_t2_wave_done", wd_seen, 0);
    do_tick();
    chk("drain_t3_count", active_count, 0);
    chk("drain_wave_done_once", wd_seen, 1);
    chk("drain_idle_ready", spawn_ready, 0);

    // ticks arriving during SCAN
    restart();
    spawn(100, 100, 1, 0, 4, 0);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    cyc(3);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    cyc(1);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    cyc(N + 12);
    chk("overrun_flag", tick_overrun, 1);
    rd_index = 3'd0;
    cyc(1);
    chk("pending_moved_pos", rd_pos, {8'd102, 8'd100});
    player_x = 44; player_y = 44; player_size = 16;
    spawn(40, 40, 0, 0, 8, 0); expect_hit(1, 95, 0); do_tick();
    chk("slot1_hit_hp", hp, 95);

    // reset asserted in the middle of a scan
    spawn(40, 40, 0, 0, 8, 0);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midscan_count", active_count, 0);
    chk("midscan_hp", hp, 100);
    chk("midscan_overrun", tick_overrun, 0);
    chk("midscan_ready", spawn_ready, 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
